// File: rtl/dmem_responder_if.sv
// Load/store port bundle between the core (master) and the data-memory responder (slave).
// Carries a request channel and a response channel, each with its own valid/ready pair.
// ADDR_W must match the responder's ADDR_W.
interface dmem_responder_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, WAIT_STATES wait cycles, then a held response.
// Latency: accepted at edge k, rsp_valid driven after edge k+WAIT_STATES (sampled at k+WAIT_STATES+1).
// Backpressure: response held stable until rsp_ready; no new request accepted outside IDLE.
// Optional: define DMEM_MISALIGN_CHECK_EN to reject requests with req_addr[1:0] != 0.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  dmem_responder_if.slave    bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int CNT_W  = $clog2(WAIT_STATES + 2);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic              mem_wr;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [3:0]        cur_be;
  logic [ADDR_W-3:0] cur_word;
  logic [MEM_AW-1:0] mem_idx;
  logic              cur_err;

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  assign accept = bus.req_valid && (state_q == S_IDLE);

  // With zero wait states the access happens on the accept edge, so the live
  // request fields are used in IDLE and the latched copy everywhere else.
  assign cur_we    = (state_q == S_IDLE) ? bus.req_we    : we_q;
  assign cur_addr  = (state_q == S_IDLE) ? bus.req_addr  : addr_q;
  assign cur_wdata = (state_q == S_IDLE) ? bus.req_wdata : wdata_q;
  assign cur_be    = (state_q == S_IDLE) ? bus.req_be    : be_q;

  assign cur_word = cur_addr[ADDR_W-1:2];
  assign mem_idx  = MEM_AW'(cur_word);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign cur_err = (32'(cur_word) >= 32'(DEPTH)) || (cur_addr[1:0] != 2'b00);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cur_addr[1:0];
  assign cur_err = (32'(cur_word) >= 32'(DEPTH));
`endif

  // A write only lands if the request survives to the RESP entry edge.
  assign mem_wr = enter_resp && cur_we && !cur_err && resetn;

  // Next-state logic: IDLE -> WAIT (or RESP) -> RESP -> IDLE, response captured on RESP entry.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = CNT_LOAD;
          if (WAIT_STATES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      err_d   = cur_err;
      rdata_d = (!cur_err && !cur_we) ? mem[mem_idx] : '0;
    end
  end

  // Control and response registers with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
      end
    end
  end

  // Byte-enabled storage; contents are deliberately not reset.
  always_ff @(posedge CLOCK_50) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_be[b]) mem[mem_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus random load/store traffic against a word-array reference model.
module tb_dmem_responder;

  localparam int AW    = 11;
  localparam int DEPTH = 256;
  localparam int WS    = 2;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;

  always #5 CLOCK_50 = ~CLOCK_50;

  dmem_responder_if #(.ADDR_W(AW)) bus ();

  dmem_responder #(
    .ADDR_W      (AW),
    .DEPTH       (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: word array, byte enables, range (and optional alignment) errors.
  function automatic void model(input logic we, input logic [AW-1:0] addr,
                                input logic [31:0] wd, input logic [3:0] be,
                                output logic [31:0] rd, output logic err);
    int idx;
    idx = int'(addr) / 4;
    err = (idx >= DEPTH);
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((int'(addr) % 4) != 0) err = 1'b1;
`endif
    rd = 32'h0;
    if (!err) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
        end
      end else begin
        rd = ref_mem[idx];
      end
    end
  endfunction

  task automatic do_txn(input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int stall,
                        output logic [31:0] rd_o, output logic err_o);
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        was_rdy;
    int          n;
    model(we, addr, wd, be, exp_rd, exp_err);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_be    = be;
    n = 0;
    do begin
      was_rdy = bus.req_ready;
      @(posedge CLOCK_50); #1;
      n++;
    end while (!was_rdy && n < 20);
    // Scramble the request fields: they must be ignored once the request is taken.
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = AW'($urandom);
    bus.req_wdata = 32'($urandom);
    bus.req_be    = 4'($urandom);
    check("accept", 32'(was_rdy), 32'd1);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge CLOCK_50); #1;
      n++;
    end
    check("latency", 32'(n + 1), 32'(WS + 1));
    for (int i = 0; i < stall; i++) begin
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      check("hold_rdata", bus.rsp_rdata, exp_rd);
      check("hold_err", 32'(bus.rsp_err), 32'(exp_err));
      @(posedge CLOCK_50); #1;
    end
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_rdata", bus.rsp_rdata, exp_rd);
    check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    rd_o  = bus.rsp_rdata;
    err_o = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge CLOCK_50); #1;
    bus.rsp_ready = 1'b0;
    check("done_valid", 32'(bus.rsp_valid), 32'd0);
    check("done_req_ready", 32'(bus.req_ready), 32'd1);
    check("done_rdata", bus.rsp_rdata, 32'd0);
    check("done_err", 32'(bus.rsp_err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] rd;
  logic        er;
  logic [31:0] prior;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    resetn = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_err", 32'(bus.rsp_err), 32'd0);
    resetn = 1'b1;
    @(posedge CLOCK_50); #1;

    // Give every word a known value
    for (int i = 0; i < DEPTH; i++) begin
      do_txn(1'b1, AW'(i * 4), 32'($urandom), 4'hF, 0, rd, er);
    end

    // Round trip
    do_txn(1'b1, AW'(11'h004), 32'h12345678, 4'hF, 0, rd, er);
    check("rt_store_err", 32'(er), 32'd0);
    do_txn(1'b0, AW'(11'h004), 32'h0, 4'h0, 0, rd, er);
    check("rt_load", rd, 32'h12345678);

    // Partial write
    do_txn(1'b1, AW'(11'h008), 32'hAABBCCDD, 4'hF, 0, rd, er);
    do_txn(1'b1, AW'(11'h008), 32'h11223344, 4'b0101, 0, rd, er);
    do_txn(1'b0, AW'(11'h008), 32'h0, 4'h0, 0, rd, er);
    check("partial", rd, 32'hAA22CC44);

    // Backpressure on a load
    do_txn(1'b0, AW'(11'h008), 32'h0, 4'h0, 5, rd, er);
    check("bp_load", rd, 32'hAA22CC44);

    // Range error: word 256
    do_txn(1'b1, AW'(11'h400), 32'hCAFEF00D, 4'hF, 0, rd, er);
    check("range_err", 32'(er), 32'd1);
    check("range_rdata", rd, 32'd0);
    do_txn(1'b0, AW'(11'h7FC), 32'h0, 4'h0, 2, rd, er);
    check("range_load_err", 32'(er), 32'd1);

    // Alignment
    do_txn(1'b0, AW'(11'h005), 32'h0, 4'h0, 0, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("align_err", 32'(er), 32'd1);
    check("align_rdata", rd, 32'd0);
`else
    check("align_err", 32'(er), 32'd0);
    check("align_rdata", rd, ref_mem[1]);
`endif

    // Store with no byte enables
    prior = ref_mem[3];
    do_txn(1'b1, AW'(11'h00C), 32'h5A5A5A5A, 4'h0, 0, rd, er);
    check("be0_err", 32'(er), 32'd0);
    do_txn(1'b0, AW'(11'h00C), 32'h0, 4'h0, 0, rd, er);
    check("be0_unchanged", rd, prior);

    // Reset while a store sits in WAIT
    prior = ref_mem[4];
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = AW'(11'h010);
    bus.req_wdata = 32'hDEADBEEF;
    bus.req_be    = 4'hF;
    @(posedge CLOCK_50); #1;
    bus.req_valid = 1'b0;
    check("wait_req_ready", 32'(bus.req_ready), 32'd0);
    check("wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    resetn = 1'b0;
    @(posedge CLOCK_50); #1;
    resetn = 1'b1;
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_rdata", bus.rsp_rdata, 32'd0);
    check("midrst_err", 32'(bus.rsp_err), 32'd0);
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("midrst_quiet", 32'(bus.rsp_valid), 32'd0);
    do_txn(1'b0, AW'(11'h010), 32'h0, 4'h0, 0, rd, er);
    check("midrst_prior", rd, prior);

    // Random traffic
    for (int t = 0; t < 150; t++) begin
      logic [AW-1:0] a;
      if ($urandom_range(0, 7) == 0) a = AW'($urandom_range(0, 2047));
      else                          a = AW'($urandom_range(0, 1023));
      do_txn(1'($urandom), a, 32'($urandom), 4'($urandom), $urandom_range(0, 3), rd, er);
    end

    // Full readback: nothing written outside the model's expectations
    for (int i = 0; i < DEPTH; i++) begin
      do_txn(1'b0, AW'(i * 4), 32'h0, 4'h0, 0, rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
